// File: rtl/procyon_biu_line_fill_pkg.sv
// rtl/procyon_biu_line_fill_pkg.sv - types for the cacheline fill engine
// Provides the fill FSM state type, built on the shared encodings.
package procyon_biu_line_fill_pkg;

`include "procyon_constants.svh"

    typedef enum logic [`PCYN_BIU_STATE_WIDTH-1:0] {
        BIU_STATE_IDLE = `PCYN_BIU_STATE_IDLE,
        BIU_STATE_BUSY = `PCYN_BIU_STATE_BUSY,
        BIU_STATE_DONE = `PCYN_BIU_STATE_DONE
    } biu_state_t;

endpackage

// File: rtl/procyon_constants.svh
// rtl/procyon_constants.svh - shared encodings for the procyon bus interface unit
`ifndef PROCYON_CONSTANTS_SVH
`define PROCYON_CONSTANTS_SVH

`define PCYN_BIU_STATE_WIDTH 2
`define PCYN_BIU_STATE_IDLE  2'b00
`define PCYN_BIU_STATE_BUSY  2'b01
`define PCYN_BIU_STATE_DONE  2'b10

`endif

// File: rtl/procyon_biu_line_fill.sv
// rtl/procyon_biu_line_fill.sv - fetches one cacheline as a burst of pipelined beat reads
// Ports:
//   clk, n_rst                 clock, asynchronous active-low reset
//   i_biu_en, i_biu_addr       line fetch request (level) and line address
//   o_biu_done, o_biu_data     one-cycle completion pulse and assembled line
//   o_mem_req_valid/ready/addr beat read request channel
//   i_mem_rsp_valid/data       in-order beat read responses
module procyon_biu_line_fill
    import procyon_biu_line_fill_pkg::*;
#(
    parameter int OPTN_ADDR_WIDTH   = 32,
    parameter int OPTN_DC_LINE_SIZE = 1024,
    parameter int OPTN_BUS_WIDTH    = 32
) (
    input  logic                           clk,
    input  logic                           n_rst,

    input  logic                           i_biu_en,
    input  logic [OPTN_ADDR_WIDTH-1:0]     i_biu_addr,
    output logic                           o_biu_done,
    output logic [OPTN_DC_LINE_SIZE*8-1:0] o_biu_data,

    output logic                           o_mem_req_valid,
    input  logic                           i_mem_req_ready,
    output logic [OPTN_ADDR_WIDTH-1:0]     o_mem_req_addr,

    input  logic                           i_mem_rsp_valid,
    input  logic [OPTN_BUS_WIDTH-1:0]      i_mem_rsp_data
);

    localparam int BEATS      = OPTN_DC_LINE_SIZE * 8 / OPTN_BUS_WIDTH;
    localparam int CNT_W      = $clog2(BEATS) + 1;
    localparam int BEAT_SHIFT = $clog2(OPTN_BUS_WIDTH / 8);

    localparam logic [CNT_W-1:0]           BEATS_C   = CNT_W'(BEATS);
    localparam logic [CNT_W-1:0]           LAST_C    = CNT_W'(BEATS - 1);
    localparam logic [OPTN_ADDR_WIDTH-1:0] LINE_MASK = ~(OPTN_ADDR_WIDTH'(OPTN_DC_LINE_SIZE - 1));

    biu_state_t                 state_q, state_d;
    logic [OPTN_ADDR_WIDTH-1:0] line_addr_q, line_addr_d;
    logic [CNT_W-1:0]           req_cnt_q, req_cnt_d;
    logic [CNT_W-1:0]           rsp_cnt_q, rsp_cnt_d;
    logic [OPTN_DC_LINE_SIZE*8-1:0] data_q;

    logic req_fire;
    logic rsp_fire;

    assign o_mem_req_valid = (state_q == BIU_STATE_BUSY) && (req_cnt_q < BEATS_C);
    assign o_mem_req_addr  = line_addr_q + (OPTN_ADDR_WIDTH'(req_cnt_q) << BEAT_SHIFT);
    assign o_biu_done      = (state_q == BIU_STATE_DONE);
    assign o_biu_data      = data_q;

    assign req_fire = o_mem_req_valid && i_mem_req_ready;
    // Responses only count in BUSY; stray beats in IDLE/DONE are dropped.
    assign rsp_fire = (state_q == BIU_STATE_BUSY) && i_mem_rsp_valid;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= BIU_STATE_IDLE;
            line_addr_q <= '0;
            req_cnt_q   <= '0;
            rsp_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            line_addr_q <= line_addr_d;
            req_cnt_q   <= req_cnt_d;
            rsp_cnt_q   <= rsp_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        line_addr_d = line_addr_q;
        req_cnt_d   = req_cnt_q;
        rsp_cnt_d   = rsp_cnt_q;

        case (state_q)
            BIU_STATE_IDLE: begin
                if (i_biu_en) begin
                    state_d     = BIU_STATE_BUSY;
                    line_addr_d = i_biu_addr & LINE_MASK;
                    req_cnt_d   = '0;
                    rsp_cnt_d   = '0;
                end
            end
            BIU_STATE_BUSY: begin
                if (req_fire) begin
                    req_cnt_d = req_cnt_q + CNT_W'(1);
                end
                // Memory may answer in the same cycle it accepts a request,
                // so request and response counting are fully independent.
                if (rsp_fire) begin
                    rsp_cnt_d = rsp_cnt_q + CNT_W'(1);
                    if (rsp_cnt_q == LAST_C) begin
                        state_d = BIU_STATE_DONE;
                    end
                end
            end
            BIU_STATE_DONE: begin
                // Requester still holds en here; it is deliberately ignored.
                state_d = BIU_STATE_IDLE;
            end
            default: begin
                state_d = BIU_STATE_IDLE;
            end
        endcase
    end

    // Line buffer has no reset; it holds the last line until the next fill
    // overwrites it beat by beat.
    always_ff @(posedge clk) begin
        if (rsp_fire) begin
            for (int b = 0; b < BEATS; b++) begin
                if (rsp_cnt_q == CNT_W'(b)) begin
                    data_q[b*OPTN_BUS_WIDTH +: OPTN_BUS_WIDTH] <= i_mem_rsp_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_procyon_biu_line_fill.sv
// tb/tb_procyon_biu_line_fill.sv - scoreboard bench for the cacheline fill engine
module tb_procyon_biu_line_fill;

    localparam int AW = 32;
    localparam int LS = 16;
    localparam int BW = 32;

    localparam logic [127:0] LINE_A = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] LINE_B = 128'h04040404_03030303_02020202_01010101;
    localparam logic [127:0] LINE_C = 128'h28282828_1E1E1E1E_14141414_0A0A0A0A;

    logic            clk = 1'b0;
    logic            n_rst = 1'b0;
    logic            i_biu_en = 1'b0;
    logic [AW-1:0]   i_biu_addr = '0;
    logic            o_biu_done;
    logic [LS*8-1:0] o_biu_data;
    logic            o_mem_req_valid;
    logic            i_mem_req_ready = 1'b1;
    logic [AW-1:0]   o_mem_req_addr;
    logic            i_mem_rsp_valid = 1'b0;
    logic [BW-1:0]   i_mem_rsp_data = '0;

    always #5 clk = ~clk;

    procyon_biu_line_fill #(
        .OPTN_ADDR_WIDTH  (AW),
        .OPTN_DC_LINE_SIZE(LS),
        .OPTN_BUS_WIDTH   (BW)
    ) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .i_biu_en       (i_biu_en),
        .i_biu_addr     (i_biu_addr),
        .o_biu_done     (o_biu_done),
        .o_biu_data     (o_biu_data),
        .o_mem_req_valid(o_mem_req_valid),
        .i_mem_req_ready(i_mem_req_ready),
        .o_mem_req_addr (o_mem_req_addr),
        .i_mem_rsp_valid(i_mem_rsp_valid),
        .i_mem_rsp_data (i_mem_rsp_data)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [31:0]  aq[$];
    logic [127:0] dq[$];

    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;

    int          mem_lat = 1;
    logic [31:0] mem_base = 32'h0;
    int          stall_beat = 0;
    int          stall_left = 0;
    int          stall_seen = 0;
    bit          mem_inject = 1'b0;
    int          rsp_driven = 0;
    logic [31:0] pend[$];

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event occurred, none required", name);
    endtask

    function automatic logic [31:0] beat_data(input logic [31:0] a);
        return mem_base * (32'(a[3:2]) + 32'd1);
    endfunction

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Memory model: optional stall, 0- or 1-cycle in-order responses.
    initial forever begin
        @(negedge clk);
        i_mem_rsp_valid = 1'b0;
        i_mem_rsp_data  = '0;
        i_mem_req_ready = 1'b1;
        if (!n_rst) begin
            pend.delete();
        end else if (mem_inject) begin
            i_mem_rsp_valid = 1'b1;
            i_mem_rsp_data  = 32'hDEADBEEF;
            mem_inject      = 1'b0;
        end else begin
            if (o_mem_req_valid && o_mem_req_addr[3:2] == 2'(stall_beat) && stall_left > 0) begin
                i_mem_req_ready = 1'b0;
                stall_left--;
                stall_seen++;
            end
            if (mem_lat == 0) begin
                if (o_mem_req_valid && i_mem_req_ready) begin
                    i_mem_rsp_valid = 1'b1;
                    i_mem_rsp_data  = beat_data(o_mem_req_addr);
                    rsp_driven++;
                end
            end else begin
                if (pend.size() > 0) begin
                    i_mem_rsp_valid = 1'b1;
                    i_mem_rsp_data  = pend.pop_front();
                    rsp_driven++;
                end
                if (o_mem_req_valid && i_mem_req_ready) begin
                    pend.push_back(beat_data(o_mem_req_addr));
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a request or a done.
    logic        prev_hold = 1'b0;
    logic [31:0] prev_addr = '0;
    initial forever begin
        @(negedge clk);
        #2;
        if (!n_rst) begin
            chk32("rst_req_valid", 32'(o_mem_req_valid), 32'd0);
            chk32("rst_done", 32'(o_biu_done), 32'd0);
            chk32("rst_req_addr", o_mem_req_addr, 32'd0);
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk32("stall_valid_held", 32'(o_mem_req_valid), 32'd1);
                chk32("stall_addr_held", o_mem_req_addr, prev_addr);
            end
            prev_hold = o_mem_req_valid && !i_mem_req_ready;
            prev_addr = o_mem_req_addr;
            if (o_biu_done) begin
                done_cnt++;
                done_cyc = cyc;
                chk32("no_req_in_done", 32'(o_mem_req_valid), 32'd0);
                if (dq.size() == 0) flag("unexpected_done");
                else chk128("line_data", o_biu_data, dq.pop_front());
            end
            if (o_mem_req_valid && i_mem_req_ready) begin
                if (aq.size() == 0) flag("unexpected_req");
                else chk32("req_addr", o_mem_req_addr, aq.pop_front());
            end
        end
    end

    task automatic fill(input logic [31:0] addr, input logic [31:0] base, input int lat,
                        input int sbeat, input int scycles, input logic [127:0] exp,
                        output int c0);
        logic [31:0] line;
        int start_done;
        bit got;
        line = addr & ~32'hF;
        for (int i = 0; i < 4; i++) aq.push_back(line + 32'(4 * i));
        dq.push_back(exp);
        mem_base   = base;
        mem_lat    = lat;
        stall_beat = sbeat;
        stall_left = scycles;
        stall_seen = 0;
        @(negedge clk);
        i_biu_en   = 1'b1;
        i_biu_addr = addr;
        start_done = done_cnt;
        c0 = cyc;
        @(negedge clk);
        i_biu_addr = 32'hFFFF_FF00;
        got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            #3;
            if (done_cnt != start_done) got = 1'b1;
        end
        if (!got) flag("done_timeout");
        // en stays high through the DONE cycle and drops one cycle later.
        @(negedge clk);
        i_biu_en = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        chk32("req_drain", 32'(aq.size()), 32'd0);
        chk32("done_count", 32'(done_cnt - start_done), 32'd1);
    endtask

    initial begin
        int c0;
        bit seen;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        #4;
        chk32("post_rst_valid", 32'(o_mem_req_valid), 32'd0);
        chk32("post_rst_done", 32'(o_biu_done), 32'd0);
        chk32("post_rst_addr", o_mem_req_addr, 32'd0);

        fill(32'h0000_1234, 32'h1111_1111, 1, 0, 0, LINE_A, c0);

        fill(32'h0000_1234, 32'h1111_1111, 1, 1, 3, LINE_A, c0);
        chk32("stall_cycles", 32'(stall_seen), 32'd3);

        @(negedge clk);
        mem_inject = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        chk128("idle_rsp_ignored", o_biu_data, LINE_A);

        // Reset after two accepted responses; three requests have handshaked.
        aq.push_back(32'h1230);
        aq.push_back(32'h1234);
        aq.push_back(32'h1238);
        mem_base   = 32'h1111_1111;
        mem_lat    = 1;
        stall_left = 0;
        rsp_driven = 0;
        @(negedge clk);
        i_biu_en   = 1'b1;
        i_biu_addr = 32'h1230;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            #3;
            if (rsp_driven >= 2) seen = 1'b1;
        end
        if (!seen) flag("rsp_wait_timeout");
        @(posedge clk);
        #1;
        n_rst    = 1'b0;
        i_biu_en = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        chk32("mid_rst_valid", 32'(o_mem_req_valid), 32'd0);
        chk32("mid_rst_done", 32'(o_biu_done), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        chk32("mid_rst_req_count", 32'(aq.size()), 32'd0);
        chk32("mid_rst_no_done", 32'(dq.size()), 32'd0);

        fill(32'h0000_2000, 32'h0101_0101, 1, 0, 0, LINE_B, c0);

        fill(32'h0000_300C, 32'h0A0A_0A0A, 0, 0, 0, LINE_C, c0);
        chk32("zero_lat_done_cycle", 32'(done_cyc - c0), 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
